reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the single write port of the 16-entry register file (R0–R15) among several writeback sources, e.g. ALU result, memory load and MDR/HI-LO transfer.
- Arbitrates each cycle with a valid/ready handshake and a round-robin priority scheme.
- Registers the winning write and drives the register file's write controls (reg_addr, enable, D) for exactly one cycle.
- Sits between the datapath writeback sources and the register file.

Parameters:
- NUM_REQ, 3: number of writeback requesters (2..8).
- DATA_W, 32: write data width.
- ADDR_W, 4: register address width (16 registers).
- R0_WRITABLE, 1: if 0, writes addressed to R0 are accepted but suppressed.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester grant; a transfer occurs when valid and ready are both 1.
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
- hold  in  1  stall: no grant is issued while high.
- rf_enable  out  1  register-file load enable.
- rf_reg_addr  out  ADDR_W  register-file write address.
- rf_D  out  DATA_W  register-file write data.
- grant_id  out  clog2(NUM_REQ)  index of the requester whose write is on rf_*.
- r0_suppressed  out  1  one-cycle pulse when an R0 write is dropped.
- wr_count  out  16  saturating count of committed writes.

Behaviour:
- Reset (clr=1, asynchronous): rf_enable=0, rf_reg_addr=0, rf_D=0, grant_id=0, r0_suppressed=0, wr_count=0. The priority pointer is set so requester 0 has highest priority. req_ready is all-zero while clr=1.
- Arbitration (combinational, per cycle):
  - If hold=0 and any req_valid=1, exactly one req_ready bit is set.
  - The winner is the first valid requester found scanning from (last_granted+1) mod NUM_REQ upward, with wrap-around.
  - req_ready is otherwise 0. ready never asserts for a non-valid requester.
- Handshake:
  - A requester holds valid, addr and data stable until it sees ready.
  - It may deassert valid only after the transfer cycle.
  - ready depends combinationally on valid, hold and the pointer, so requesters must not make valid depend on ready.
- Latency: a transfer at edge N makes rf_enable=1 during cycle N+1, with rf_reg_addr, rf_D and grant_id captured from the winner. rf_enable falls after one cycle unless another transfer occurred.
- Throughput: one write per cycle. Back-to-back grants are allowed, including to different requesters on consecutive cycles.
- Pointer: on each transfer, last_granted takes the winner index. With no transfer, the pointer is unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of hold being low.
- hold=1: req_ready=0 and no capture occurs. rf_enable is 0 on the following cycle, while rf_reg_addr and rf_D keep their last values. Pending requests are not lost.
- R0 rule (R0_WRITABLE=0): a write to address 0 still handshakes and advances the pointer. On the next cycle, rf_enable=0, r0_suppressed=1 and wr_count is not incremented.
- wr_count: increments on each cycle with rf_enable=1 and saturates at 16'hFFFF.
- Reset mid-operation: a captured but uncommitted write is discarded, and no rf_enable pulse is produced after clr deasserts.

Decomposition:
- Shared package: REG_COUNT=16, ADDR_W=4, DATA_W=32, and the default NUM_REQ.
- Sub-module rr_arbiter: combinational rotating-priority one-hot grant, with inputs req, ptr and enable, and outputs a one-hot grant and its encoded index.
- The top level holds the pointer register, the output register stage, R0 suppression and the counter.

Test Plan:
- Reset then idle: clr pulse, all valid=0 → rf_enable=0, outputs 0, wr_count=0, req_ready=000.
- Single requester: req1 valid, addr=5, data=32'hDEADBEEF → ready[1]=1 for one cycle; next cycle rf_enable=1, rf_reg_addr=5, rf_D=DEADBEEF, grant_id=1; wr_count=1.
- Contention: all 3 valid continuously with distinct addresses 1, 2, 3 → grants in order 0,1,2,0,… and rf_enable high every cycle.
- Hold: all valid, hold=1 for 4 cycles → req_ready=000 and rf_enable=0. After release, grants resume from the pointer without any lost request.
- R0 suppression (R0_WRITABLE=0): req0 writes addr=0 → handshake completes; next cycle rf_enable=0 and r0_suppressed=1; wr_count unchanged.
- Async reset mid-write: assert clr between a transfer and its commit → no rf_enable pulse, and after release requester 0 wins the first contention.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// ============================================================================
// reg_write_arbiter_pkg : shared sizes for the register-file write arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package reg_write_arbiter_pkg;
   localparam int REG_COUNT   = 16;
   localparam int RF_ADDR_W   = $clog2(REG_COUNT);
   localparam int RF_DATA_W   = 32;
   localparam int DEF_NUM_REQ = 3;
   localparam int CNT_W       = 16;

   // Index width for N requesters; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

`default_nettype wire

// File: rtl/reg_write_arbiter_if.sv
// ============================================================================
// reg_write_arbiter_if : writeback request bus and register-file write port
// Rev 1.0
// ============================================================================
`default_nettype none

interface reg_write_arbiter_if
   import reg_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int DATA_W  = RF_DATA_W,
   parameter int ADDR_W  = RF_ADDR_W
);
   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      hold;
   logic                      rf_enable;
   logic [ADDR_W-1:0]         rf_reg_addr;
   logic [DATA_W-1:0]         rf_D;
   logic [ID_W-1:0]           grant_id;
   logic                      r0_suppressed;
   logic [CNT_W-1:0]          wr_count;

   modport master (
      output req_valid, req_addr, req_data, hold,
      input  req_ready, rf_enable, rf_reg_addr, rf_D, grant_id, r0_suppressed, wr_count
   );

   modport slave (
      input  req_valid, req_addr, req_data, hold,
      output req_ready, rf_enable, rf_reg_addr, rf_D, grant_id, r0_suppressed, wr_count
   );
endinterface

`default_nettype wire

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational rotating-priority one-hot grant
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o
);

   // ptr_i is the last winner, so the scan starts one past it and wraps.
   always_comb begin
      logic            found;
      logic [ID_W-1:0] cand;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
         if (en_i && !found && req_i[cand]) begin
            found        = 1'b1;
            gnt_o[cand]  = 1'b1;
            idx_o        = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// reg_write_arbiter : round-robin sharing of the register-file write port
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int DATA_W      = RF_DATA_W,
   parameter int ADDR_W      = RF_ADDR_W,
   parameter int R0_WRITABLE = 1
) (
   input  logic                 clk,
   input  logic                 clr,
   reg_write_arbiter_if.slave   bus_io
);

   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               xfer;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_data;
   logic               drop;

   logic [ID_W-1:0]    ptr_q,  ptr_d;
   logic               en_q,   en_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [ID_W-1:0]    id_q,   id_d;
   logic               sup_q,  sup_d;
   logic [CNT_W-1:0]   cnt_q,  cnt_d;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req_i (bus_io.req_valid),
      .ptr_i (ptr_q),
      .en_i  (!bus_io.hold && !clr),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   assign bus_io.req_ready = gnt;

   always_comb begin
      xfer     = |gnt;
      win_addr = bus_io.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      win_data = bus_io.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
      drop     = xfer && (win_addr == '0) && (R0_WRITABLE == 0);

      ptr_d  = ptr_q;
      addr_d = addr_q;
      data_d = data_q;
      id_d   = id_q;
      if (xfer) begin
         ptr_d  = gnt_idx;
         addr_d = win_addr;
         data_d = win_data;
         id_d   = gnt_idx;
      end

      // A dropped R0 write still handshakes but never reaches the file.
      en_d  = xfer && !drop;
      sup_d = drop;

      // The count already includes the write being presented on rf_*.
      cnt_d = cnt_q;
      if (en_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         ptr_q  <= ID_W'(NUM_REQ - 1);
         en_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         id_q   <= '0;
         sup_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         ptr_q  <= ptr_d;
         en_q   <= en_d;
         addr_q <= addr_d;
         data_q <= data_d;
         id_q   <= id_d;
         sup_q  <= sup_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus_io.rf_enable     = en_q;
   assign bus_io.rf_reg_addr   = addr_q;
   assign bus_io.rf_D          = data_q;
   assign bus_io.grant_id      = id_q;
   assign bus_io.r0_suppressed = sup_q;
   assign bus_io.wr_count      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// tb_reg_write_arbiter : directed bench with a behavioural reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;
   localparam int N = 3;

   logic        clk;
   logic        clr;
   logic [2:0]  tv;
   logic        thold;
   logic [3:0]  ta [N];
   logic [31:0] td [N];

   int n_checks = 0;
   int n_err    = 0;

   // ifa: R0 writable; ifb: R0 writes suppressed. Both see identical stimulus.
   reg_write_arbiter_if #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(4)) ifa ();
   reg_write_arbiter_if #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(4)) ifb ();

   assign ifa.req_valid = tv;
   assign ifa.hold      = thold;
   assign ifa.req_addr  = {ta[2], ta[1], ta[0]};
   assign ifa.req_data  = {td[2], td[1], td[0]};
   assign ifb.req_valid = tv;
   assign ifb.hold      = thold;
   assign ifb.req_addr  = {ta[2], ta[1], ta[0]};
   assign ifb.req_data  = {td[2], td[1], td[0]};

   reg_write_arbiter #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(4), .R0_WRITABLE(1)) dut_a (
      .clk    (clk),
      .clr    (clr),
      .bus_io (ifa)
   );

   reg_write_arbiter #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(4), .R0_WRITABLE(0)) dut_b (
      .clk    (clk),
      .clr    (clr),
      .bus_io (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: first valid requester after the last winner, wrapping.
   function automatic int pick(input logic [2:0] v, input logic h, input int last);
      if (h) return -1;
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   int          m_last = N - 1;
   logic [3:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   int          m_gid  = 0;
   logic        m_en  [2] = '{1'b0, 1'b0};
   logic        m_sup [2] = '{1'b0, 1'b0};
   int          m_cnt [2] = '{0, 0};

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         m_last = N - 1;
         m_addr = '0;
         m_data = '0;
         m_gid  = 0;
         for (int j = 0; j < 2; j++) begin
            m_en[j]  = 1'b0;
            m_sup[j] = 1'b0;
            m_cnt[j] = 0;
         end
      end else begin
         int w;
         w = pick(tv, thold, m_last);
         for (int j = 0; j < 2; j++) begin
            m_en[j]  = 1'b0;
            m_sup[j] = 1'b0;
         end
         if (w >= 0) begin
            m_last = w;
            m_addr = ta[w];
            m_data = td[w];
            m_gid  = w;
            for (int j = 0; j < 2; j++) begin
               if (j == 1 && ta[w] == 4'd0) begin
                  m_sup[j] = 1'b1;
               end else begin
                  m_en[j] = 1'b1;
                  if (m_cnt[j] < 65535) m_cnt[j] = m_cnt[j] + 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      int   w;
      logic [2:0] er;
      w  = clr ? -1 : pick(tv, thold, m_last);
      er = (w >= 0) ? (3'b001 << w) : 3'b000;
      chk("ready_a", 64'(ifa.req_ready), 64'(er));
      chk("ready_b", 64'(ifb.req_ready), 64'(er));
      chk("en_a",    64'(ifa.rf_enable), 64'(m_en[0]));
      chk("en_b",    64'(ifb.rf_enable), 64'(m_en[1]));
      chk("sup_a",   64'(ifa.r0_suppressed), 64'(m_sup[0]));
      chk("sup_b",   64'(ifb.r0_suppressed), 64'(m_sup[1]));
      chk("cnt_a",   64'(ifa.wr_count), 64'(m_cnt[0]));
      chk("cnt_b",   64'(ifb.wr_count), 64'(m_cnt[1]));
      chk("addr_a",  64'(ifa.rf_reg_addr), 64'(m_addr));
      chk("addr_b",  64'(ifb.rf_reg_addr), 64'(m_addr));
      chk("data_a",  64'(ifa.rf_D), 64'(m_data));
      chk("data_b",  64'(ifb.rf_D), 64'(m_data));
      chk("gid_a",   64'(ifa.grant_id), 64'(m_gid));
      chk("gid_b",   64'(ifb.grant_id), 64'(m_gid));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int seq_c [6] = '{2, 0, 1, 2, 0, 1};
   int seq_h [3] = '{2, 0, 1};

   initial begin
      clr   = 1'b1;
      tv    = 3'b000;
      thold = 1'b0;
      for (int i = 0; i < N; i++) begin
         ta[i] = '0;
         td[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;

      // Reset, idle
      @(negedge clk);
      chk("rst_en",    64'(ifa.rf_enable), 64'd0);
      chk("rst_cnt",   64'(ifa.wr_count), 64'd0);
      chk("rst_ready", 64'(ifa.req_ready), 64'd0);
      chk("rst_D",     64'(ifa.rf_D), 64'd0);

      // Single requester
      step();
      tv = 3'b010; ta[1] = 4'd5; td[1] = 32'hDEADBEEF;
      @(negedge clk);
      chk("single_ready", 64'(ifa.req_ready), 64'b010);
      step();
      tv = 3'b000;
      @(negedge clk);
      chk("single_en",   64'(ifa.rf_enable), 64'd1);
      chk("single_addr", 64'(ifa.rf_reg_addr), 64'd5);
      chk("single_D",    64'(ifa.rf_D), 64'hDEADBEEF);
      chk("single_gid",  64'(ifa.grant_id), 64'd1);
      chk("single_cnt",  64'(ifa.wr_count), 64'd1);
      step();
      @(negedge clk);
      chk("single_fall", 64'(ifa.rf_enable), 64'd0);
      chk("single_keep", 64'(ifa.rf_reg_addr), 64'd5);

      // Contention: last winner was 1
      step();
      tv = 3'b111;
      ta[0] = 4'd1; ta[1] = 4'd2; ta[2] = 4'd3;
      td[0] = 32'hA0; td[1] = 32'hA1; td[2] = 32'hA2;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("cont_ready", 64'(ifa.req_ready), 64'(3'b001 << seq_c[k]));
         step();
      end

      // Hold for 4 cycles with all requesters pending
      thold = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("hold_ready", 64'(ifa.req_ready), 64'd0);
         chk("hold_en",    64'(ifa.rf_enable), (k == 0) ? 64'd1 : 64'd0);
         step();
      end
      thold = 1'b0;
      @(negedge clk);
      chk("hold_keep_addr", 64'(ifa.rf_reg_addr), 64'd2);
      chk("hold_en_off",    64'(ifa.rf_enable), 64'd0);
      chk("hold_cnt",       64'(ifa.wr_count), 64'd7);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         chk("resume_ready", 64'(ifa.req_ready), 64'(3'b001 << seq_h[k]));
         step();
      end
      tv = 3'b000;
      @(negedge clk);
      chk("resume_cnt", 64'(ifa.wr_count), 64'd10);

      // R0 write: accepted by both, suppressed only on dut_b
      step();
      tv = 3'b001; ta[0] = 4'd0; td[0] = 32'h12345678;
      @(negedge clk);
      chk("r0_ready", 64'(ifb.req_ready), 64'b001);
      step();
      tv = 3'b000;
      @(negedge clk);
      chk("r0_en_a",  64'(ifa.rf_enable), 64'd1);
      chk("r0_cnt_a", 64'(ifa.wr_count), 64'd11);
      chk("r0_en_b",  64'(ifb.rf_enable), 64'd0);
      chk("r0_sup_b", 64'(ifb.r0_suppressed), 64'd1);
      chk("r0_cnt_b", 64'(ifb.wr_count), 64'd10);
      step();
      @(negedge clk);
      chk("r0_sup_pulse", 64'(ifb.r0_suppressed), 64'd0);

      // Asynchronous reset between capture and commit
      step();
      tv = 3'b010; ta[1] = 4'd7; td[1] = 32'h77;
      @(negedge clk);
      chk("mid_ready", 64'(ifa.req_ready), 64'b010);
      step();
      tv = 3'b000;
      #1 clr = 1'b1;
      #1;
      chk("mid_en_cut", 64'(ifa.rf_enable), 64'd0);
      chk("mid_cnt",    64'(ifa.wr_count), 64'd0);
      @(posedge clk);
      #1 clr = 1'b0;
      tv = 3'b111;
      @(negedge clk);
      chk("post_rst_en",    64'(ifa.rf_enable), 64'd0);
      chk("post_rst_ready", 64'(ifa.req_ready), 64'b001);
      step();
      tv = 3'b000;
      @(negedge clk);
      chk("post_rst_gid", 64'(ifa.grant_id), 64'd0);
      chk("post_rst_cnt", 64'(ifa.wr_count), 64'd1);
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
